// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction register and a request/valid handshake with program RAM.
// Optional WAIT-state timeout is enabled with the FETCH_TIMEOUT_EN macro.
module fetch_unit #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [DATA_W-1:0] pc_din,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_nx_s;
    logic [DATA_W-1:0]   instr_r;
    logic                instr_valid_r;
    logic                mem_req_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                busy_r;
    logic                pend_r;
    logic                pend_nx_s;
    logic [ADDR_W-1:0]   pend_val_r;
    logic [ADDR_W-1:0]   pend_val_nx_s;
    logic [ADDR_W-1:0]   load_addr_s;
    logic                start_s;
    logic                done_s;
    logic                tmo_s;
    logic                tmo_hit_s;

    assign load_addr_s = pc_din[ADDR_W-1:0];

    generate
        if (DATA_W > ADDR_W) begin : g_unused_bus
            logic unused_bus_s;
            assign unused_bus_s = ^pc_din[DATA_W-1:ADDR_W];
        end
    endgenerate

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             fetch_err_r;

    // The final WAIT cycle without data is the one where the counter already holds TIMEOUT-1.
    assign tmo_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // WAIT-cycle counter, cleared while the request strobe is out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_REQ) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && !mem_valid) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err_r <= 1'b0;
        end else begin
            fetch_err_r <= tmo_s;
        end
    end

    assign fetch_err = fetch_err_r;
`else
    assign tmo_hit_s = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; fetch_req is only honoured in IDLE, mem_valid only in WAIT.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        done_s     = 1'b0;
        tmo_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fetch_req) begin
                    state_nx_s = ST_REQ;
                    start_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    state_nx_s = ST_IDLE;
                    done_s     = 1'b1;
                end else if (tmo_hit_s) begin
                    state_nx_s = ST_IDLE;
                    tmo_s      = 1'b1;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // PC update: direct load when idle, otherwise loads are parked until the fetch ends.
    always_comb begin
        pc_nx_s       = pc_r;
        pend_nx_s     = pend_r;
        pend_val_nx_s = pend_val_r;
        if (state_r == ST_IDLE) begin
            if (pc_load) begin
                pc_nx_s = load_addr_s;
            end else begin
                pc_nx_s = pc_r;
            end
        end else if (done_s || tmo_s) begin
            pend_nx_s = 1'b0;
            if (pc_load) begin
                pc_nx_s = load_addr_s;
            end else if (pend_r) begin
                pc_nx_s = pend_val_r;
            end else if (done_s) begin
                pc_nx_s = pc_r + ADDR_W'(1);
            end else begin
                pc_nx_s = pc_r;
            end
        end else if (pc_load) begin
            pend_nx_s     = 1'b1;
            pend_val_nx_s = load_addr_s;
        end else begin
            pend_nx_s = pend_r;
        end
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            instr_r       <= {DATA_W{1'b0}};
            instr_valid_r <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            busy_r        <= 1'b0;
            pend_r        <= 1'b0;
            pend_val_r    <= {ADDR_W{1'b0}};
        end else begin
            pc_r          <= pc_nx_s;
            pend_r        <= pend_nx_s;
            pend_val_r    <= pend_val_nx_s;
            instr_valid_r <= done_s;
            mem_req_r     <= start_s;
            busy_r        <= (state_nx_s != ST_IDLE);
            if (start_s) begin
                mem_addr_r <= pc_nx_s;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (done_s) begin
                instr_r <= mem_rdata;
            end else begin
                instr_r <= instr_r;
            end
        end
    end

    assign pc          = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign mem_req     = mem_req_r;
    assign mem_addr    = mem_addr_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable RAM responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] pc_din;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_valid = 1'b0;
    logic [15:0] instr;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        busy;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ram [0:255];
    int          lat     = 1;
    bit          ram_en  = 1'b1;
    int          rsp_cnt = 0;
    logic [7:0]  rsp_addr = 8'h00;

    fetch_unit dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load), .pc_din(pc_din),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // RAM answers a request after 'lat' cycles with a one-cycle valid.
    always @(posedge clk) begin
        if (mem_req && ram_en) begin
            rsp_addr <= mem_addr;
            if (lat <= 1) begin
                mem_valid <= 1'b1;
                mem_rdata <= ram[mem_addr];
                rsp_cnt   <= 0;
            end else begin
                mem_valid <= 1'b0;
                rsp_cnt   <= lat - 1;
            end
        end else if (rsp_cnt > 1) begin
            rsp_cnt   <= rsp_cnt - 1;
            mem_valid <= 1'b0;
        end else if (rsp_cnt == 1) begin
            rsp_cnt   <= 0;
            mem_valid <= 1'b1;
            mem_rdata <= ram[rsp_addr];
        end else begin
            mem_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (instr_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_din = 16'h0000;
        tick(); tick();
        rst = 1'b0;
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc: got %h want 00", pc); end
        checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL reset_instr: got %h want 0000", instr); end
        checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0 || fetch_err !== 1'b0)
            begin failures++; $display("FAIL reset_flags: valid=%b req=%b busy=%b err=%b want 0000", instr_valid, mem_req, busy, fetch_err); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    endtask

    task automatic test_basic();
        lat = 1;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || busy !== 1'b1)
            begin failures++; $display("FAIL basic_req: req=%b addr=%h busy=%b want 1 00 1", mem_req, mem_addr, busy); end
        tick();
        checks++; if (mem_req !== 1'b0 || busy !== 1'b1 || instr_valid !== 1'b0)
            begin failures++; $display("FAIL basic_wait: req=%b busy=%b valid=%b want 0 1 0", mem_req, busy, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || pc !== 8'h01 || busy !== 1'b0)
            begin failures++; $display("FAIL basic_done: valid=%b instr=%h pc=%h busy=%b want 1 1234 01 0", instr_valid, instr, pc, busy); end
        tick();
        checks++; if (instr_valid !== 1'b0 || instr !== 16'h1234)
            begin failures++; $display("FAIL basic_hold: valid=%b instr=%h want 0 1234", instr_valid, instr); end
    endtask

    task automatic test_wrap();
        int n;
        pc_load = 1'b1; pc_din = 16'h00FF;
        tick();
        pc_load = 1'b0;
        checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL wrap_load: got %h want ff", pc); end
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        checks++; if (mem_addr !== 8'hFF) begin failures++; $display("FAIL wrap_addr: got %h want ff", mem_addr); end
        wait_valid(10, n);
        checks++; if (n !== 2 || instr !== 16'hBEEF || pc !== 8'h00)
            begin failures++; $display("FAIL wrap_done: n=%0d instr=%h pc=%h want 2 beef 00", n, instr, pc); end
        tick();
    endtask

    task automatic test_pending_load();
        int n;
        pc_load = 1'b1; pc_din = 16'h0005;
        tick();
        pc_load = 1'b0;
        lat = 3;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        pc_load = 1'b1; pc_din = 16'h0040;
        tick();
        pc_load = 1'b0;
        checks++; if (pc !== 8'h05) begin failures++; $display("FAIL pend_hold: got %h want 05", pc); end
        wait_valid(10, n);
        checks++; if (n !== 2 || instr !== 16'hFA05 || pc !== 8'h40)
            begin failures++; $display("FAIL pend_done: n=%0d instr=%h pc=%h want 2 fa05 40", n, instr, pc); end
        tick();
        lat = 1;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        checks++; if (mem_addr !== 8'h40) begin failures++; $display("FAIL pend_next_addr: got %h want 40", mem_addr); end
        wait_valid(10, n);
        checks++; if (instr !== 16'hBF40 || pc !== 8'h41)
            begin failures++; $display("FAIL pend_next: instr=%h pc=%h want bf40 41", instr, pc); end
        tick();
    endtask

    task automatic test_back_to_back();
        int reqs = 0;
        int busys = 0;
        int valids = 0;
        lat = 4;
        fetch_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_req === 1'b1) reqs++;
            if (busy === 1'b1) busys++;
            if (instr_valid === 1'b1) valids++;
            if (i == 5) fetch_req = 1'b0;
        end
        checks++; if (reqs !== 1 || busys !== 5 || valids !== 1)
            begin failures++; $display("FAIL held_req: reqs=%0d busy=%0d valids=%0d want 1 5 1", reqs, busys, valids); end
        checks++; if (instr !== 16'hBE41 || pc !== 8'h42)
            begin failures++; $display("FAIL held_data: instr=%h pc=%h want be41 42", instr, pc); end
        lat = 1;
    endtask

    task automatic test_reset_mid_fetch();
        lat = 2;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (pc !== 8'h00 || instr !== 16'h0000 || busy !== 1'b0 || instr_valid !== 1'b0)
            begin failures++; $display("FAIL rstmid_state: pc=%h instr=%h busy=%b valid=%b want 00 0000 0 0", pc, instr, busy, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || pc !== 8'h00)
            begin failures++; $display("FAIL rstmid_late: valid=%b instr=%h pc=%h want 0 0000 00", instr_valid, instr, pc); end
        lat = 1;
    endtask

    task automatic test_timeout();
        int n;
        int bad = 0;
        pc_load = 1'b1; pc_din = 16'h0010;
        tick();
        pc_load = 1'b0;
        ram_en = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        n = 1;
        while (fetch_err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== 17 || pc !== 8'h10 || instr !== 16'h0000 || busy !== 1'b0 || instr_valid !== 1'b0)
            begin failures++; $display("FAIL timeout_pulse: n=%0d pc=%h instr=%h busy=%b want 17 10 0000 0", n, pc, instr, busy); end
        tick();
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL timeout_width: got %b want 0", fetch_err); end
`else
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b1 || fetch_err !== 1'b0) bad++;
            n++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL wait_unbounded: bad=%0d of %0d want 0", bad, n); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || pc !== 8'h00) begin failures++; $display("FAIL wait_recover: busy=%b pc=%h want 0 00", busy, pc); end
`endif
        ram_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'(((~i & 8'hFF) << 8) | i);
        ram[8'h00] = 16'h1234;
        ram[8'hFF] = 16'hBEEF;
        test_reset();
        test_basic();
        test_wrap();
        test_pending_load();
        test_back_to_back();
        test_reset_mid_fetch();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the CPU control unit.
- Holds the program counter (PC) and the instruction register, and runs a request/valid handshake with program RAM.
- Presents a stable 16-bit instruction word plus a one-cycle valid strobe to the control unit.
- Supports PC load from the datapath bus for jumps and branches.

Parameters:
- DATA_W, 16, instruction/bus width.
- ADDR_W, 8, PC and RAM address width.
- RESET_PC, 0, PC value after reset (ADDR_W bits).
- TIMEOUT, 15, WAIT-state cycle limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  control unit requests the next instruction; sampled in IDLE only.
- pc_load  in  1  load PC from pc_din.
- pc_din  in  DATA_W  bus value; low ADDR_W bits used.
- mem_req  out  1  one-cycle RAM read strobe.
- mem_addr  out  ADDR_W  registered RAM read address.
- mem_rdata  in  DATA_W  RAM read data.
- mem_valid  in  1  RAM read data valid.
- instr  out  DATA_W  instruction register, held until the next completed fetch.
- instr_valid  out  1  one-cycle pulse when instr updates.
- pc  out  ADDR_W  current PC, for the control unit's pcout path.
- busy  out  1  high in REQ and WAIT.
- fetch_err  out  1  timeout pulse; constant 0 without the macro.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, mem_req=0, mem_addr=0, busy=0, fetch_err=0, pending load cleared.
  - Reset mid-fetch abandons the fetch; a late mem_valid is ignored because the block is in IDLE.
- FSM states IDLE, REQ, WAIT.
- IDLE:
  - pc_load=1 sets pc<=pc_din[ADDR_W-1:0].
  - fetch_req=1 moves to REQ.
  - If pc_load and fetch_req are asserted together, both are accepted and REQ uses the newly loaded PC.
- REQ (exactly 1 cycle):
  - mem_req=1, mem_addr=pc, busy=1; then go to WAIT.
- WAIT:
  - busy=1; stay until mem_valid=1.
  - On mem_valid: instr<=mem_rdata, instr_valid pulses for 1 cycle, go to IDLE.
  - Also on mem_valid: pc<=pc+1 modulo 2^ADDR_W (0xFF wraps to 0x00), unless a pending load exists; in that case pc<=pending value and the pending flag clears.
- Latency: fetch_req in cycle N gives mem_req in N+1. If RAM returns mem_valid in N+2, instr_valid is high in N+3. Minimum fetch is 3 cycles.
- pc_load while busy: value captured as pending and applied at fetch completion. It overrides the increment. The instruction already in flight is still delivered. A later pc_load while busy overwrites the pending value.
- fetch_req while busy: ignored, not queued.
- mem_valid outside WAIT: ignored.
- mem_valid in the same cycle as mem_req (REQ): ignored; data is accepted only in WAIT.
- instr changes only on a completed fetch or on reset.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without mem_valid.
  - When it reaches TIMEOUT, fetch_err pulses 1 cycle and state goes to IDLE.
  - On timeout, instr, instr_valid and pc are unchanged; a pending load is applied.
  - mem_valid in the same cycle as the timeout wins: normal completion, no error.
- Not defined: WAIT is unbounded, no counter logic, fetch_err tied 0.

Test Plan:
- Reset, then RAM[0]=16'h1234 with 1-cycle RAM latency and fetch_req pulsed -> mem_req with mem_addr=0x00 next cycle; instr=16'h1234, instr_valid one cycle, pc=0x01.
- pc_load with pc_din=16'h00FF in IDLE, RAM[0xFF]=16'hBEEF, then fetch -> mem_addr=0xFF, instr=16'hBEEF, pc wraps to 0x00.
- pc_load with pc_din=0x40 during WAIT at pc=0x05 -> instr=RAM[0x05] delivered, pc=0x40 (not 0x06); next fetch addresses 0x40.
- fetch_req held high through WAIT with RAM delaying mem_valid 4 cycles -> only one mem_req; busy high 5 cycles; one instr_valid.
- rst asserted during WAIT, mem_valid arrives the next cycle -> pc=RESET_PC, instr=0, no instr_valid.
- With FETCH_TIMEOUT_EN, TIMEOUT=15 and mem_valid never asserted -> fetch_err pulses after 15 WAIT cycles, state IDLE, pc and instr unchanged; without the macro -> busy stays high, fetch_err=0.
